// File: rtl/uart_cmd_loader_if.sv
// Byte-stream command bus between the host byte source and uart_cmd_loader.
//   rx_valid/rx_data            : received byte strobe and value (host -> loader)
//   imem_we/imem_addr/imem_wdata: instruction memory write port (loader -> core)
//   dmem_we/dmem_addr/dmem_wdata: data memory write port (loader -> core)
//   step/run                    : single-step pulse and sticky free-run enable
//   busy/err/err_count          : frame in progress, error pulse, saturating error count
// Modport slave is the loader side, modport master is the byte-source/observer side.
interface uart_cmd_loader_if #(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned ADDR_W     = 8
);
  localparam int unsigned W = 8 * WORD_BYTES;

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [W-1:0]      imem_wdata;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [W-1:0]      dmem_wdata;
  logic              step;
  logic              run;
  logic              busy;
  logic              err;
  logic [7:0]        err_count;

  modport slave (
    input  rx_valid, rx_data,
    output imem_we, imem_addr, imem_wdata,
    output dmem_we, dmem_addr, dmem_wdata,
    output step, run, busy, err, err_count
  );

  modport master (
    output rx_valid, rx_data,
    input  imem_we, imem_addr, imem_wdata,
    input  dmem_we, dmem_addr, dmem_wdata,
    input  step, run, busy, err, err_count
  );
endinterface

// File: rtl/uart_cmd_loader.sv
// Byte-stream command decoder: frames {opcode, WORD_BYTES little-endian payload
// bytes}, commits assembled words to imem/dmem through auto-incrementing
// pointers, loads both pointers on SET_ADDR, and drives step/run control.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : uart_cmd_loader_if.slave (rx byte in; memory writes, control, status out)
// All outputs are registered.
module uart_cmd_loader #(
  parameter int unsigned WORD_BYTES     = 4,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned ADDR_STEP      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic             clk,
  input  logic             reset,
  uart_cmd_loader_if.slave bus
);
  localparam int unsigned W      = 8 * WORD_BYTES;
  localparam int unsigned IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [7:0] OP_LOAD_I   = 8'h00;
  localparam logic [7:0] OP_LOAD_D   = 8'h01;
  localparam logic [7:0] OP_STEP     = 8'h02;
  localparam logic [7:0] OP_RUN      = 8'h03;
  localparam logic [7:0] OP_HALT     = 8'h04;
  localparam logic [7:0] OP_SET_ADDR = 8'h05;

  typedef enum logic {
    ST_IDLE,
    ST_PAYLOAD
  } state_e;

  // Destination of the payload currently being assembled.
  typedef enum logic [1:0] {
    TGT_IMEM,
    TGT_DMEM,
    TGT_ADDR
  } tgt_e;

  state_e            state_q,      state_d;
  tgt_e              tgt_q,        tgt_d;
  logic [IDX_W-1:0]  idx_q,        idx_d;
  logic [W-1:0]      word_q,       word_d;
  logic [TCNT_W-1:0] tcnt_q,       tcnt_d;
  logic              imem_we_q,    imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q,  imem_addr_d;
  logic [W-1:0]      imem_wdata_q, imem_wdata_d;
  logic              dmem_we_q,    dmem_we_d;
  logic [ADDR_W-1:0] dmem_addr_q,  dmem_addr_d;
  logic [W-1:0]      dmem_wdata_q, dmem_wdata_d;
  logic              step_q,       step_d;
  logic              run_q,        run_d;
  logic              busy_q,       busy_d;
  logic              err_q,        err_d;
  logic [7:0]        err_count_q,  err_count_d;
  logic              err_set;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tgt_q        <= TGT_IMEM;
      idx_q        <= '0;
      word_q       <= '0;
      tcnt_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      step_q       <= 1'b0;
      run_q        <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      tcnt_q       <= tcnt_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      step_q       <= step_d;
      run_q        <= run_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      err_count_q  <= err_count_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    idx_d        = idx_q;
    word_d       = word_q;
    tcnt_d       = tcnt_q;
    imem_we_d    = 1'b0;
    imem_wdata_d = imem_wdata_q;
    dmem_we_d    = 1'b0;
    dmem_wdata_d = dmem_wdata_q;
    step_d       = 1'b0;
    run_d        = run_q;
    err_set      = 1'b0;

    // Pointers advance on the edge that ends their write-enable cycle.
    imem_addr_d = imem_we_q ? imem_addr_q + ADDR_W'(ADDR_STEP) : imem_addr_q;
    dmem_addr_d = dmem_we_q ? dmem_addr_q + ADDR_W'(ADDR_STEP) : dmem_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          case (bus.rx_data)
            OP_LOAD_I, OP_LOAD_D, OP_SET_ADDR: begin
              state_d = ST_PAYLOAD;
              idx_d   = '0;
              word_d  = '0;
              tcnt_d  = '0;
              if (bus.rx_data == OP_LOAD_I) begin
                tgt_d = TGT_IMEM;
              end else if (bus.rx_data == OP_LOAD_D) begin
                tgt_d = TGT_DMEM;
              end else begin
                tgt_d = TGT_ADDR;
              end
            end
            OP_STEP: step_d  = 1'b1;
            OP_RUN:  run_d   = 1'b1;
            OP_HALT: run_d   = 1'b0;
            default: err_set = 1'b1;
          endcase
        end
      end

      ST_PAYLOAD: begin
        if (bus.rx_valid) begin
          // A byte on the deadline cycle still wins over the timeout.
          tcnt_d = '0;
          for (int unsigned b = 0; b < WORD_BYTES; b++) begin
            if (idx_q == IDX_W'(b)) begin
              word_d[8*b +: 8] = bus.rx_data;
            end
          end
          if (idx_q == IDX_W'(WORD_BYTES - 1)) begin
            state_d = ST_IDLE;
            case (tgt_q)
              TGT_IMEM: begin
                imem_we_d    = 1'b1;
                imem_wdata_d = word_d;
              end
              TGT_DMEM: begin
                dmem_we_d    = 1'b1;
                dmem_wdata_d = word_d;
              end
              TGT_ADDR: begin
                imem_addr_d = ADDR_W'(word_d);
                dmem_addr_d = ADDR_W'(word_d);
              end
              default: ;
            endcase
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES)) begin
          // Abandon the partial frame; nothing is written.
          state_d = ST_IDLE;
          err_set = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    err_d       = err_set;
    err_count_d = (err_set && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
    busy_d      = (state_d == ST_PAYLOAD);
  end

  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_wdata = dmem_wdata_q;
  assign bus.step       = step_q;
  assign bus.run        = run_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
  assign bus.err_count  = err_count_q;
endmodule

// File: doc/uart_cmd_loader.md
Name: uart_cmd_loader

Overview:
Byte-stream command decoder between the UART receiver and the RISC-V core's memories and run control. Frames each command as one opcode byte plus WORD_BYTES little-endian payload bytes. Writes assembled words into instruction or data memory through auto-incrementing pointers, and drives step/run control. Generalises the fixed 4-byte instruction loader: parametrised word width and address width, a data-memory path, address set, run/halt, inter-byte timeout and error accounting.

Parameters:
WORD_BYTES, 4, payload bytes per word; word width W = 8*WORD_BYTES
ADDR_W, 8, width of the imem/dmem pointers
ADDR_STEP, 4, pointer increment after each committed write
TIMEOUT_CYCLES, 20000, maximum idle cycles between payload bytes before the frame is aborted

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_valid  in  1  single-cycle strobe: rx_data holds a received byte
rx_data  in  8  received byte
imem_we  out  1  one-cycle instruction-memory write strobe
imem_addr  out  ADDR_W  instruction pointer
imem_wdata  out  W  assembled instruction word
dmem_we  out  1  one-cycle data-memory write strobe
dmem_addr  out  ADDR_W  data pointer
dmem_wdata  out  W  assembled data word
step  out  1  one-cycle single-step pulse to the core
run  out  1  sticky free-run enable
busy  out  1  high while a payload frame is in progress
err  out  1  one-cycle error pulse
err_count  out  8  saturating error counter

Behaviour:
- Reset is synchronous, active-high; clk is the only clock. On reset all outputs are 0, state is IDLE, the partial frame is discarded and both pointers are 0. Reset applied mid-frame has the same effect.
- Opcodes:
  - 0x00 LOAD_I: payload goes to imem.
  - 0x01 LOAD_D: payload goes to dmem.
  - 0x02 STEP: no payload.
  - 0x03 RUN: no payload.
  - 0x04 HALT: no payload.
  - 0x05 SET_ADDR: payload; the low ADDR_W bits load both imem_addr and dmem_addr.
  - Any other opcode is an error.
- States: IDLE and PAYLOAD.
- IDLE, on rx_valid:
  - Opcodes 0x00, 0x01, 0x05: latch the opcode, clear the byte index, go to PAYLOAD, busy=1.
  - 0x02: step=1 on the next cycle for exactly one cycle.
  - 0x03: run=1 from the next cycle. 0x04: run=0 from the next cycle.
  - Unknown opcode: err pulse on the next cycle, err_count+1, stay in IDLE.
- PAYLOAD, on rx_valid: store the byte at bits [8*idx+7 : 8*idx] (first byte is LSB) and increment idx. This also resets the timeout counter.
- Final byte (idx = WORD_BYTES-1):
  - Return to IDLE; busy=0 on the next cycle.
  - On the next cycle the target *_wdata holds the full word and the matching *_we is high for one cycle, with *_addr equal to the pre-increment pointer.
  - The pointer increments by ADDR_STEP on the edge that ends the we cycle.
  - SET_ADDR produces no we.
- Latency: final byte strobe at cycle N → we at N+1 → pointer updated at N+2.
- Pointer wrap: arithmetic is modulo 2^ADDR_W with no error; e.g. 0xFC+4 = 0x00 for ADDR_W=8.
- *_wdata holds its last committed value until the next commit to the same memory.
- Timeout:
  - In PAYLOAD, a counter increments every cycle without rx_valid.
  - When it reaches TIMEOUT_CYCLES: discard the frame, return to IDLE, pulse err, err_count+1, no write.
  - A byte strobe arriving on the same cycle the counter reaches TIMEOUT_CYCLES is accepted and the timeout is cancelled.
- err_count saturates at 255.
- run is unaffected by frame errors and timeouts.
- step asserted while run=1 is still emitted; the core decides what to do with it.
- rx_valid on the cycle after a final byte is processed normally as a new opcode in IDLE; back-to-back strobes lose nothing.
- imem and dmem writes are never asserted in the same cycle.

Test Plan:
- Reset, then bytes 00 13 01 50 00 → imem_we one cycle after the last strobe, imem_addr=0x00, imem_wdata=0x00500113; next cycle imem_addr=0x04, busy=0.
- SET_ADDR 05 FC 00 00 00, then two LOAD_I frames → writes at 0xFC then 0x00 (wrap); dmem_addr=0xFC, no dmem_we.
- 01 07 00 00 00 → dmem_we, dmem_wdata=0x00000007, dmem_addr=0; imem_addr unchanged.
- Bytes 02, 03, 04 → single-cycle step; run rises after 03 and falls after 04.
- 00 AA then silence for TIMEOUT_CYCLES → one err pulse, err_count=1, no imem_we, busy=0; a following valid LOAD_I still writes at the original address. Opcode 0x7F ×300 → err_count saturates at 255.
- Reset asserted after 00 13 01 → all outputs 0; next full LOAD_I writes imem_addr=0 with the fresh payload only.
